// File: rtl/i2c_slave_rx.sv
// ---------------------------------------------------------------------------
// I2cSlaveRx: write-only I2C target receiver.
//
// Purpose:
//   Watches an I2C bus through double-flop synchronisers, recognises START
//   and STOP, takes in the address byte and acknowledges it when it matches
//   SLAVE_ADDR with the write bit clear. After that it takes in any number of
//   data bytes, acknowledges each one and presents it on rx_data with a
//   one-cycle rx_valid strobe. Any other address (or a read) is ignored until
//   the next START or STOP.
//
// Ports:
//   clk        in   system clock, everything on its rising edge
//   rst_n      in   asynchronous active-low reset
//   scl        in   bus clock from the master (asynchronous to clk)
//   sda_in     in   bus data line as seen on the wire
//   sda_oe     out  1 = pull SDA low (ACK), 0 = release; registered
//   rx_data    out  last received data byte
//   rx_valid   out  one-clk pulse when rx_data updates
//   addr_match out  high from the address ACK until STOP / repeated START
//   busy       out  high between a detected START and a detected STOP
// ---------------------------------------------------------------------------
module i2c_slave_rx #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_match,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } state_e;

    state_e     state_q;
    logic       sclMeta_q, sclS_q, sclD_q;
    logic       sdaMeta_q, sdaS_q, sdaD_q;
    logic [2:0] bitCnt_q;
    logic [7:0] shift_q;
    logic       byteDone_q;
    logic       sdaOe_q;
    logic [7:0] rxData_q;
    logic       rxValid_q;
    logic       addrMatch_q;
    logic       busy_q;

    logic riseEv, fallEv, startEv, stopEv;

    // Two flops bring each bus line into the clk domain; the third flop keeps
    // the previous synchronised value so edges can be seen. Resetting them to
    // 1 matches an idle bus, so no edge is seen when reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclMeta_q <= 1'b1;
            sclS_q    <= 1'b1;
            sclD_q    <= 1'b1;
            sdaMeta_q <= 1'b1;
            sdaS_q    <= 1'b1;
            sdaD_q    <= 1'b1;
        end else begin
            sclMeta_q <= scl;
            sclS_q    <= sclMeta_q;
            sclD_q    <= sclS_q;
            sdaMeta_q <= sda_in;
            sdaS_q    <= sdaMeta_q;
            sdaD_q    <= sdaS_q;
        end
    end

    // START and STOP are SDA edges while SCL is steadily high.
    assign riseEv  =  sclS_q & ~sclD_q;
    assign fallEv  = ~sclS_q &  sclD_q;
    assign startEv =  sclS_q &  sclD_q & ~sdaS_q &  sdaD_q;
    assign stopEv  =  sclS_q &  sclD_q &  sdaS_q & ~sdaD_q;

    // Protocol FSM. START/STOP are checked first so they win over any SCL
    // edge in the same cycle. A completed byte is flagged by byteDone_q and
    // evaluated one clk later from the full shift register; SCL is at least
    // eight clks per period, so the next SCL edge is still several clks away.
    // In the ACK states the first fall starts driving SDA low and the second
    // fall releases it, so sdaOe_q itself marks which half of the slot we are in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bitCnt_q    <= 3'd7;
            shift_q     <= 8'h00;
            byteDone_q  <= 1'b0;
            sdaOe_q     <= 1'b0;
            rxData_q    <= 8'h00;
            rxValid_q   <= 1'b0;
            addrMatch_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rxValid_q <= 1'b0;
            if (startEv) begin
                state_q     <= ADDR;
                bitCnt_q    <= 3'd7;
                byteDone_q  <= 1'b0;
                addrMatch_q <= 1'b0;
                busy_q      <= 1'b1;
                sdaOe_q     <= 1'b0;
            end else if (stopEv) begin
                state_q     <= IDLE;
                byteDone_q  <= 1'b0;
                addrMatch_q <= 1'b0;
                busy_q      <= 1'b0;
                sdaOe_q     <= 1'b0;
            end else begin
                unique case (state_q)
                    ADDR, DATA: begin
                        if (byteDone_q) begin
                            byteDone_q <= 1'b0;
                            if (state_q == ADDR) begin
                                if (shift_q[7:1] == SLAVE_ADDR && !shift_q[0]) begin
                                    state_q <= ADDR_ACK;
                                end else begin
                                    state_q <= IGNORE;
                                end
                            end else begin
                                rxData_q  <= shift_q;
                                rxValid_q <= 1'b1;
                                state_q   <= DATA_ACK;
                            end
                        end else if (riseEv) begin
                            shift_q  <= {shift_q[6:0], sdaS_q};
                            bitCnt_q <= bitCnt_q - 3'd1;
                            if (bitCnt_q == 3'd0) begin
                                byteDone_q <= 1'b1;
                            end
                        end
                    end
                    ADDR_ACK, DATA_ACK: begin
                        if (fallEv) begin
                            if (!sdaOe_q) begin
                                sdaOe_q <= 1'b1;
                            end else begin
                                sdaOe_q  <= 1'b0;
                                bitCnt_q <= 3'd7;
                                state_q  <= DATA;
                            end
                        end else if (riseEv && sdaOe_q && state_q == ADDR_ACK) begin
                            addrMatch_q <= 1'b1;
                        end
                    end
                    default: begin
                        // IDLE and IGNORE only leave on START or STOP.
                    end
                endcase
            end
        end
    end

    assign sda_oe     = sdaOe_q;
    assign rx_data    = rxData_q;
    assign rx_valid   = rxValid_q;
    assign addr_match = addrMatch_q;
    assign busy       = busy_q;

endmodule

// File: doc/i2c_slave_rx.md
I2C_SLAVE_RX -- requirements
Module: i2c_slave_rx

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50, the 7-bit target address this receiver acknowledges.
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset, asynchronous and active-low.
REQ-004 SHALL have port scl, input, 1, the bus clock from the I2C master, asynchronous to clk.
REQ-005 SHALL have port sda_in, input, 1, the bus data line as seen on the wire.
REQ-006 SHALL have port sda_oe, output, 1, where 1 means pull SDA low (open-drain ACK) and 0 means release.
REQ-007 SHALL have port rx_data, output, 8, the last received data byte.
REQ-008 SHALL have port rx_valid, output, 1, a one-clk pulse when rx_data updates.
REQ-009 SHALL have port addr_match, output, 1, high from the address ACK until STOP or repeated START.
REQ-010 SHALL have port busy, output, 1, high between a detected START and a detected STOP.

Function
REQ-011 SHALL synchronise scl and sda_in through two flops each (scl_s, sda_s), plus one history flop each (scl_d, sda_d).
REQ-012 SHALL use these event definitions:
- rise: scl_s=1 and scl_d=0.
- fall: scl_s=0 and scl_d=1.
- START: scl_s=1, scl_d=1, sda_s=0, sda_d=1.
- STOP: scl_s=1, scl_d=1, sda_s=1, sda_d=0.
REQ-013 SHALL implement FSM states IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK and IGNORE, with a 3-bit bit counter and an 8-bit shift register.
REQ-014 SHALL go from any state to ADDR on START, with bit counter=7, addr_match=0, busy=1 and sda_oe=0, including a repeated START while busy.
REQ-015 SHALL go from any state to IDLE on STOP, with busy=0, addr_match=0 and sda_oe=0; a partial byte is discarded and no rx_valid is issued.
REQ-016 SHALL give START/STOP priority over rise/fall in the same clk cycle.
REQ-017 In ADDR and DATA, SHALL on each rise shift sda_s into the LSB of the shift register (MSB first on the wire) and decrement the bit counter.
REQ-018 SHALL treat the rise that occurs with counter=0 as completing the byte.
REQ-019 SHALL handle ADDR byte completion as follows:
- If byte[7:1]==SLAVE_ADDR and byte[0]==0 (write): go to ADDR_ACK.
- Otherwise: go to IGNORE.
REQ-020 In ADDR_ACK, SHALL set sda_oe=1 on the first fall.
REQ-021 In ADDR_ACK, SHALL set addr_match=1 on the following rise.
REQ-022 In ADDR_ACK, SHALL on the next fall set sda_oe=0, set counter=7 and go to DATA.
REQ-023 On DATA byte completion, SHALL load rx_data with the byte, pulse rx_valid for exactly one clk in the following cycle, and go to DATA_ACK.
REQ-024 DATA_ACK SHALL drive the ACK like ADDR_ACK (sda_oe=1 on first fall, release on next fall), then return to DATA with counter=7, so multi-byte writes are supported.
REQ-025 IGNORE SHALL keep sda_oe=0 and rx_valid=0 and leave only on START or STOP.
REQ-026 In IDLE, rise/fall SHALL have no effect, and sda_oe SHALL never be 1 outside ADDR_ACK and DATA_ACK.
REQ-027 SHALL tolerate clk/SCL ratios of 8 or more; latency from a pin edge to detection SHALL be 3 clk.
REQ-028 sda_oe SHALL be registered (no combinational path from inputs).

Reset
REQ-029 While rst_n=0, SHALL asynchronously force:
- state=IDLE;
- sda_oe=0, rx_data=8'h00, rx_valid=0, addr_match=0, busy=0;
- synchroniser and history flops to 1.
REQ-030 Deassertion of rst_n mid-transfer SHALL leave the block in IDLE, ignoring bus activity until the next START.

Verification
REQ-031 SHALL cover: START, byte 8'hA0, ACK slot, byte 8'hA5, ACK slot, STOP -> sda_oe=1 across both ACK high-SCL phases, addr_match=1, one rx_valid with rx_data=8'hA5, busy=0 after STOP.
REQ-032 SHALL cover: address byte 8'hB0 then data 8'h3C -> sda_oe never 1, addr_match=0, no rx_valid.
REQ-033 SHALL cover: address byte 8'hA1 (read) -> no ACK, IGNORE until STOP, no rx_valid.
REQ-034 SHALL cover: 8'hA0, 8'h11, 8'h22 then STOP -> two rx_valid pulses with rx_data 8'h11 then 8'h22, each ACKed.
REQ-035 SHALL cover: STOP after 4 data bits, and separately rst_n=0 mid-byte -> immediate IDLE, sda_oe=0, no rx_valid; a following full transfer succeeds.
REQ-036 SHALL cover: repeated START during DATA followed by 8'hA0, 8'h5A -> restart in ADDR, ACK, rx_data=8'h5A.
